// File: rtl/vga_scanout.sv
// vga_scanout: SVGA framebuffer scanout, integer down-scaling, aligned RGB.
// Optional colour-bar source: define VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int PIX_W       = 12,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblank_in,
  input  logic              vblank_in,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [PIX_W-1:0]  fb_data,
  input  logic              pattern_sel,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int D  = MEM_LATENCY + 1;
  localparam logic [ADDR_W-1:0] LINE_W =
    ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [YW-1:0] YMASK =
    YW'((1 << SCALE_SHIFT) - 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic              hb_q;
  logic              vb_q;
  logic              synced;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] line_base;
  logic              hb_rise;
  logic              vb_fall;
  logic              live;
  logic              active;
  logic              clr;
  logic              x_end;
  logic              step_y;
  logic              tag;
  logic              rd;
  logic [11:0]       pix;
  logic [D-1:0]      hs_d;
  logic [D-1:0]      vs_d;
  logic [D-1:0]      act_d;
  logic [D-1:0]      tag_d;

  // After reset nothing is shown until a clean frame start is seen.
  always_comb begin
    hb_rise = hblank_in && !hb_q;
    vb_fall = vb_q && !vblank_in;
    live    = synced || vb_fall;
    active  = live && !hblank_in && !vblank_in;
    clr     = vblank_in || !live;
    x_end   = (x == X_LAST);
    step_y  = hb_rise && !vb_q && (y != Y_LAST);
    tag     = active && (x == '0) && (y == '0);
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      hb_q      <= 1'b0;
      vb_q      <= 1'b0;
      synced    <= 1'b0;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      fb_addr   <= '0;
      fb_rd_en  <= 1'b0;
    end else begin
      hb_q     <= hblank_in;
      vb_q     <= vblank_in;
      fb_addr  <= line_base + ADDR_W'(x >> SCALE_SHIFT);
      fb_rd_en <= rd;
      if (vb_fall)
        synced <= 1'b1;
      if (clr || hb_rise)
        x <= '0;
      else if (active && !x_end)
        x <= x + 1'b1;
      if (clr) begin
        y         <= '0;
        line_base <= '0;
      end else if (step_y) begin
        y <= y + 1'b1;
        if ((y & YMASK) == YMASK)
          line_base <= line_base + LINE_W;
      end
    end
  end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W);

  logic [BW-1:0]     bar_cnt;
  logic [2:0]        bar;
  logic [D-1:0]      pat_d;
  logic [D-1:0][2:0] bar_d;
  logic [2:0]        bo;

  assign rd  = active && !pattern_sel;
  assign bo  = bar_d[D-1];
  assign pix = pat_d[D-1] ? {{4{bo[2]}}, {4{bo[1]}}, {4{bo[0]}}}
                          : fb_data[11:0];

  // Bar index tracked alongside x so no divider is needed.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      bar_cnt <= '0;
      bar     <= '0;
      pat_d   <= '0;
      bar_d   <= '0;
    end else begin
      pat_d <= {pat_d[D-2:0], pattern_sel};
      bar_d <= {bar_d[D-2:0], bar};
      if (clr || hb_rise) begin
        bar_cnt <= '0;
        bar     <= '0;
      end else if (active && !x_end) begin
        if (bar_cnt == BW'(BAR_W - 1)) begin
          bar_cnt <= '0;
          bar     <= bar + 1'b1;
        end else begin
          bar_cnt <= bar_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_pattern_sel;

  assign unused_pattern_sel = pattern_sel;
  assign rd  = active;
  assign pix = fb_data[11:0];
`endif

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      hs_d        <= '0;
      vs_d        <= '0;
      act_d       <= '0;
      tag_d       <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      hs_d        <= {hs_d[D-2:0], hsync_in};
      vs_d        <= {vs_d[D-2:0], vsync_in};
      act_d       <= {act_d[D-2:0], active};
      tag_d       <= {tag_d[D-2:0], tag};
      hsync       <= hs_d[D-1];
      vsync       <= vs_d[D-1];
      frame_start <= tag_d[D-1];
      if (act_d[D-1])
        {red, green, blue} <= pix;
      else
        {red, green, blue} <= 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: random line lengths vs a coordinate-level model,
// plus vector checks on addresses, sync latency and frame_start counts.
module tb_vga_scanout;
  localparam int HA  = 800;
  localparam int VA  = 600;
  localparam int S   = 2;
  localparam int AW  = 15;
  localparam int PW  = 12;
  localparam int ML  = 2;
  localparam int LAT = ML + 2;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic          clk_pixel = 1'b0;
  logic          reset_n = 1'b1;
  logic          hsync_in = 1'b1;
  logic          vsync_in = 1'b0;
  logic          hblank_in = 1'b1;
  logic          vblank_in = 1'b1;
  logic          pattern_sel = 1'b0;
  logic [AW-1:0] fb_addr;
  logic          fb_rd_en;
  logic [PW-1:0] fb_data;
  logic [PW-1:0] m1;
  logic [3:0]    red;
  logic [3:0]    green;
  logic [3:0]    blue;
  logic          hsync;
  logic          vsync;
  logic          frame_start;

  vga_scanout #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SCALE_SHIFT(S),
    .ADDR_W(AW), .PIX_W(PW), .MEM_LATENCY(ML)
  ) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
    .pattern_sel(pattern_sel),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        rd;
    logic        fs;
    logic [11:0] rgb;
    int          addr;
  } rec_t;

  typedef struct {
    int line;
    int col;
    int addr;
  } vec_t;

  rec_t q[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rst = 1'b1;
  bit   live = 1'b0;
  bit   pvb = 1'b0;
  bit   mem_const = 1'b0;
  bit   last_rd = 1'b0;
  int   last_addr = 0;
  int   pend = -1;
  int   t_hs_in = -1;
  bit   hs_armed = 1'b0;
  bit   hs_done = 1'b0;
  logic prev_hs_in = 1'b1;
  logic prev_hs_out = 1'b0;
  int   fs_cnt = 0;

  function automatic logic [11:0] memf(input int a);
    if (mem_const)
      return 12'hFFF;
    return 12'(a * 37 + (a >> 4) + 5);
  endfunction

  // Framebuffer with ML registered stages.
  always @(posedge clk_pixel) begin
    m1      <= memf(int'(fb_addr));
    fb_data <= m1;
  end

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0h want %0h", nm, cyc, got, want);
    end
  endtask

  task automatic step(input logic hb, input logic vb, input logic hs,
                      input logic vs, input int line, input int col);
    rec_t r;
    rec_t e;
    rec_t z;
    int sl;
    int sc;
    logic [2:0] b;
    z = '{hs: 0, vs: 0, rd: 0, fs: 0, rgb: 0, addr: 0};
    if (q.size() == LAT) begin
      e = q.pop_front();
      chk("rgb", {red, green, blue}, e.rgb);
      chk("hsync", hsync, e.hs);
      chk("vsync", vsync, e.vs);
      chk("frame_start", frame_start, e.fs);
    end
    chk("fb_rd_en", fb_rd_en, last_rd);
    if (last_rd)
      chk("fb_addr", fb_addr, last_addr);
    if (pend >= 0)
      chk("addr_vec", fb_addr, pend);
    pend = -1;
    if (frame_start)
      fs_cnt++;
    if (hs_armed && !hs_done && t_hs_in >= 0 && prev_hs_out && !hsync) begin
      chk("hsync_lat", cyc - t_hs_in, LAT);
      hs_done = 1'b1;
    end
    prev_hs_out = hsync;

    hblank_in = hb;
    vblank_in = vb;
    hsync_in  = hs;
    vsync_in  = vs;
    reset_n   = !rst;
    r = z;
    if (rst) begin
      q.delete();
      repeat (LAT - 1) q.push_back(z);
      live = 1'b0;
      pvb  = 1'b0;
    end else begin
      if (pvb && !vb)
        live = 1'b1;
      pvb  = vb;
      r.hs = hs;
      r.vs = vs;
      if (live && !hb && !vb) begin
        sl = (line < VA - 1) ? line : VA - 1;
        sc = (col < HA - 1) ? col : HA - 1;
        r.addr = (sl >> S) * (HA >> S) + (sc >> S);
        r.rd   = !(PAT && pattern_sel);
        r.fs   = (line == 0 && col == 0);
        b      = 3'(sc / (HA / 8));
        if (PAT && pattern_sel)
          r.rgb = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
        else
          r.rgb = memf(r.addr);
        for (int i = 0; i < 12; i++)
          if (r.rd && tbl[i].line == line && tbl[i].col == col)
            pend = tbl[i].addr;
      end
      if (hs_armed && t_hs_in < 0 && prev_hs_in && !hs)
        t_hs_in = cyc;
    end
    prev_hs_in = hs;
    @(posedge clk_pixel);
    q.push_back(r);
    last_rd   = r.rd;
    last_addr = r.addr;
    @(negedge clk_pixel);
    cyc++;
  endtask

  task automatic do_line(input int l, input int nact, input bit vb,
                         input bit vs, input int rst_col);
    int nh;
    nh = $urandom_range(8, 3);
    for (int c = 0; c < nh; c++)
      step(1'b1, vb, !(c == 1 || c == 2), vs, l, -1);
    for (int c = 0; c < nact; c++) begin
      rst = (rst_col >= 0 && c >= rst_col && c < rst_col + 3);
      step(1'b0, vb, 1'b1, vs, l, c);
    end
    rst = 1'b0;
  endtask

  task automatic vblank(input int exp_fs);
    for (int v = 0; v < 3; v++)
      do_line(-1, 6, 1'b1, v == 1, -1);
    chk("frame_start_count", fs_cnt, exp_fs);
    fs_cnt = 0;
  endtask

  task automatic frame(input int nl, input int rst_line, input bit pat,
                       input bit cst, input int exp_fs);
    int len;
    vblank(exp_fs);
    mem_const   = cst;
    pattern_sel = pat;
    for (int l = 0; l < nl; l++) begin
      if (pat && l == 0)
        len = HA;
      else if (l == VA - 1)
        len = HA + 5;
      else if (l < 9)
        len = $urandom_range(12, 8);
      else
        len = $urandom_range(12, 1);
      do_line(l, len, 1'b0, 1'b0, (l == rst_line) ? 2 : -1);
    end
  endtask

  initial begin
    tbl = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 2, 0}, '{0, 3, 0},
            '{0, 4, 1}, '{0, 5, 1}, '{0, 6, 1}, '{0, 7, 1},
            '{4, 0, 200}, '{5, 7, 201}, '{599, 799, 29999},
            '{599, 804, 29999}};
    #1 reset_n = 1'b0;
    @(negedge clk_pixel);
    rst = 1'b1;
    for (int i = 0; i < 10; i++)
      step(i % 4 < 2, i % 5 == 0, i % 3 != 0, i % 7 == 0, 0, i);
    rst = 1'b0;
    hs_armed = 1'b1;
    frame(VA, -1, 1'b0, 1'b0, 0);
    frame(VA, 300, 1'b0, 1'b0, 1);
    frame(VA, -1, 1'b0, 1'b1, 1);
    frame(10, -1, PAT, 1'b0, 1);
    frame(20, -1, 1'b0, 1'b0, 1);
    vblank(1);
    if (!hs_done)
      chk("hsync_lat_seen", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
